// File: rtl/sha256_stream_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks and appends 0x80, zero fill and the 64-bit bit length.
// Latency: last beat -> PAD -> block two cycles later; a full block is offered one cycle after its last beat; blocks hold until blk_ready.
module sha256_stream_padder #(
  parameter int BYTES_PER_BEAT = 4,
  parameter int CNT_W          = $clog2(BYTES_PER_BEAT) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [8*BYTES_PER_BEAT-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  input  logic [CNT_W-1:0]            in_nbytes,
  output logic [511:0]                blk_data,
  output logic                        blk_valid,
  input  logic                        blk_ready,
  output logic                        blk_first,
  output logic                        blk_last,
  output logic                        busy,
  output logic                        done
);

  if (!(BYTES_PER_BEAT == 1 || BYTES_PER_BEAT == 2 ||
        BYTES_PER_BEAT == 4 || BYTES_PER_BEAT == 8)) begin : g_bad_cfg
    $error("sha256_stream_padder: BYTES_PER_BEAT must be 1, 2, 4 or 8");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_PAD, ST_EMIT, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [63:0][7:0]   blk_q, blk_d;       // blk_q[63] is message byte 0
  logic [6:0]         idx_q, idx_d;
  logic [60:0]        total_q, total_d;
  logic               need_len_q, need_len_d;
  logic               final_q, final_d;
  logic               first_q, first_d;
  logic               bnd_q, bnd_d;

  logic [6:0]         nbytes;
  logic [6:0]         fill;
  logic [63:0]        bit_len;

  assign nbytes  = in_last ? 7'(in_nbytes) : 7'(BYTES_PER_BEAT);
  assign fill    = idx_q + nbytes;
  assign bit_len = {total_q, 3'b000};

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    idx_d      = idx_q;
    total_d    = total_q;
    need_len_d = need_len_q;
    final_d    = final_q;
    first_d    = first_q;
    bnd_d      = bnd_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          idx_d      = '0;
          total_d    = '0;
          need_len_d = 1'b0;
          final_d    = 1'b0;
          bnd_d      = 1'b0;
          first_d    = 1'b1;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          // idx_q is beat-aligned here, so a beat never straddles the block end
          for (int j = 0; j < BYTES_PER_BEAT; j++) begin
            if (j < int'(nbytes)) begin
              blk_d[6'(63 - int'(idx_q) - j)] = in_data[8*(BYTES_PER_BEAT-1-j) +: 8];
            end
          end
          idx_d   = fill;
          total_d = total_q + 61'(nbytes);
          if (fill == 7'd64) begin
            state_d = ST_EMIT;
            if (in_last) begin
              need_len_d = 1'b1;
              bnd_d      = 1'b1;
            end
          end else if (in_last) begin
            state_d = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        for (int k = 0; k < 64; k++) begin
          if (7'(k) == idx_q) begin
            blk_d[6'(63 - k)] = 8'h80;
          end else if (7'(k) > idx_q) begin
            blk_d[6'(63 - k)] = 8'h00;
          end
        end
        if (idx_q <= 7'd55) begin
          blk_d[7:0] = bit_len;
          final_d    = 1'b1;
        end else begin
          need_len_d = 1'b1;
        end
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (blk_ready) begin
          first_d = 1'b0;
          if (final_q) begin
            state_d = ST_DONE;
          end else if (need_len_q) begin
            // trailing length-only block; 0x80 leads it only if the data ended exactly on a block edge
            blk_d      = '0;
            blk_d[63]  = bnd_q ? 8'h80 : 8'h00;
            blk_d[7:0] = bit_len;
            final_d    = 1'b1;
            need_len_d = 1'b0;
          end else begin
            idx_d   = '0;
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      blk_q      <= '0;
      idx_q      <= '0;
      total_q    <= '0;
      need_len_q <= 1'b0;
      final_q    <= 1'b0;
      first_q    <= 1'b0;
      bnd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      idx_q      <= idx_d;
      total_q    <= total_d;
      need_len_q <= need_len_d;
      final_q    <= final_d;
      first_q    <= first_d;
      bnd_q      <= bnd_d;
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign blk_valid = (state_q == ST_EMIT);
  assign blk_first = blk_valid & first_q;
  assign blk_last  = blk_valid & final_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign blk_data  = blk_q;

endmodule

// File: tb/tb_sha256_stream_padder.sv
// Bench for sha256_stream_padder: reference padding model plus literal spot values for known messages.
module tb_sha256_stream_padder;
  localparam int BPB = 4;
  localparam int CW  = 3;

  logic           clk, rst, start, abort;
  logic [8*BPB-1:0] in_data;
  logic           in_valid, in_ready, in_last;
  logic [CW-1:0]  in_nbytes;
  logic [511:0]   blk_data;
  logic           blk_valid, blk_ready, blk_first, blk_last, busy, done;

  sha256_stream_padder #(.BYTES_PER_BEAT(BPB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_nbytes(in_nbytes),
    .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_first(blk_first), .blk_last(blk_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           errors = 0;
  int           checks = 0;
  logic [7:0]   msg[$];
  logic [511:0] exp_blk[$];
  int           exp_ptr = 0;
  bit           exp_done = 1'b0;
  bit           stall_mode = 1'b0;
  int           stall_cnt = 0;
  logic [511:0] last_seen = '0;
  logic [511:0] prev_data = '0;
  bit           prev_hold = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference padding: msg || 0x80 || zeros up to 56 mod 64 || 64-bit big-endian bit count
  task automatic model_build();
    logic [7:0]  p[$];
    logic [63:0] bits;
    logic [511:0] v;
    p = msg;
    bits = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    exp_blk.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      v = '0;
      for (int k = 0; k < 64; k++) v[511-8*k -: 8] = p[64*b+k];
      exp_blk.push_back(v);
    end
    exp_ptr = 0;
  endtask

  task automatic model_clear();
    exp_blk.delete();
    exp_ptr = 0;
  endtask

  task automatic set_msg(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'(i * 7 + 3));
  endtask

  task automatic set_abc();
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
  endtask

  // Block-side monitor and blk_ready driver, all decided on the falling edge
  initial begin
    blk_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_done  = 1'b0;
        prev_hold = 1'b0;
        stall_cnt = 0;
      end else begin
        chk("done_pulse", 512'(done), 512'(exp_done));
        exp_done = 1'b0;
        if (blk_valid) begin
          chk("in_ready_in_emit", 512'(in_ready), 512'(0));
          if (prev_hold) chk("hold_stable", blk_data, prev_data);
          if (exp_ptr < exp_blk.size()) begin
            chk("blk_data", blk_data, exp_blk[exp_ptr]);
            chk("blk_first", 512'(blk_first), 512'(exp_ptr == 0));
            chk("blk_last", 512'(blk_last), 512'(exp_ptr == exp_blk.size() - 1));
          end else begin
            chk("unexpected_blk", 512'(blk_valid), 512'(0));
          end
          last_seen = blk_data;
          if (!stall_mode) begin
            blk_ready = 1'b1;
          end else if (stall_cnt >= 5) begin
            blk_ready = 1'b1;
            stall_cnt = 0;
          end else begin
            blk_ready = 1'b0;
            stall_cnt++;
          end
          prev_data = blk_data;
          prev_hold = !blk_ready;
          if (blk_ready) begin
            if (exp_ptr == exp_blk.size() - 1) exp_done = 1'b1;
            exp_ptr++;
          end
        end else begin
          blk_ready = !stall_mode;
          stall_cnt = 0;
          prev_hold = 1'b0;
        end
      end
    end
  end

  task automatic start_msg();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Sends msg beats with in_valid held high; stop_at >= 0 stops (non-last) once that many bytes went out
  task automatic send(input int stop_at);
    int sent = 0;
    int rem, nb, cyc;
    bit lst, hs;
    do begin
      rem = msg.size() - sent;
      lst = (rem <= BPB) && (stop_at < 0);
      nb  = (rem < BPB) ? rem : BPB;
      in_data = {BPB{8'hEE}};
      for (int j = 0; j < nb; j++) in_data[8*(BPB-1-j) +: 8] = msg[sent+j];
      in_valid  = 1'b1;
      in_last   = lst;
      in_nbytes = lst ? CW'(nb) : CW'(1);
      cyc = 0;
      do begin
        @(negedge clk); hs = in_ready;
        @(posedge clk); #1;
        cyc++;
      end while (!hs && cyc < 200);
      chk("beat_accept", 512'(hs), 512'(1));
      sent += nb;
    end while (!lst && !(stop_at >= 0 && sent >= stop_at));
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < 500);
    chk("done_seen", 512'(done), 512'(1));
    chk("all_blocks", 512'(exp_ptr), 512'(exp_blk.size()));
    @(negedge clk);
    chk("idle_after_done", 512'(busy), 512'(0));
  endtask

  task automatic run_msg();
    model_build();
    start_msg();
    send(-1);
    wait_done();
  endtask

  task automatic run_abc_and_check(input string tag);
    set_abc();
    run_msg();
    chk(tag, last_seen, {32'h61626380, 416'h0, 64'h18});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_nbytes = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_in_ready",  512'(in_ready),  512'(0));
    chk("rst_blk_valid", 512'(blk_valid), 512'(0));
    chk("rst_flags",     512'({blk_first, blk_last, busy, done}), 512'(0));
    chk("rst_blk_data",  blk_data, 512'(0));
    #5 rst = 1'b0;

    // "abc": model pinned to the literal, then first-block latency
    set_abc();
    model_build();
    chk("model_abc_n", 512'(exp_blk.size()), 512'(1));
    chk("model_abc", exp_blk[0], {32'h61626380, 416'h0, 64'h18});
    start_msg();
    send(-1);
    @(negedge clk); chk("pad_cycle_no_valid", 512'(blk_valid), 512'(0));
    @(negedge clk); chk("emit_latency", 512'(blk_valid), 512'(1));
    wait_done();
    chk("abc_block", last_seen, {32'h61626380, 416'h0, 64'h18});

    // empty message
    set_msg(0); run_msg();
    chk("empty_block", last_seen, {8'h80, 504'h0});

    set_msg(55); model_build();
    chk("model_55_n", 512'(exp_blk.size()), 512'(1));
    run_msg();
    chk("len_55", 512'(last_seen[63:0]), 512'(64'h1B8));

    set_msg(56); model_build();
    chk("model_56_n", 512'(exp_blk.size()), 512'(2));
    run_msg();
    chk("blk2_56", last_seen, {448'h0, 64'h1C0});

    set_msg(64); model_build();
    chk("model_64_n", 512'(exp_blk.size()), 512'(2));
    run_msg();
    chk("blk2_64", last_seen, {8'h80, 440'h0, 64'h200});

    // 130 bytes with 5-cycle stalls on every block
    stall_mode = 1'b1;
    set_msg(130); model_build();
    chk("model_130_n", 512'(exp_blk.size()), 512'(3));
    run_msg();
    chk("len_130", 512'(last_seen[63:0]), 512'(64'h410));
    stall_mode = 1'b0;

    // abort during LOAD
    set_msg(40); model_build();
    start_msg();
    send(20);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_load_busy", 512'(busy), 512'(0));
    chk("abort_load_valid", 512'(blk_valid), 512'(0));
    model_clear();
    repeat (3) @(posedge clk);
    run_abc_and_check("abc_after_abort_load");

    // abort during EMIT (block held by stall)
    stall_mode = 1'b1;
    set_msg(100); model_build();
    start_msg();
    send(64);
    @(negedge clk); chk("emit_before_abort", 512'(blk_valid), 512'(1));
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_emit_valid", 512'(blk_valid), 512'(0));
    chk("abort_emit_busy", 512'(busy), 512'(0));
    model_clear();
    stall_mode = 1'b0;
    repeat (3) @(posedge clk);
    run_abc_and_check("abc_after_abort_emit");

    // async reset between edges while a block is on offer
    stall_mode = 1'b1;
    set_msg(10); model_build();
    start_msg();
    send(-1);
    @(negedge clk);
    @(negedge clk); chk("emit_before_rst", 512'(blk_valid), 512'(1));
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 512'(blk_valid), 512'(0));
    chk("arst_flags", 512'({in_ready, blk_first, blk_last, busy, done}), 512'(0));
    chk("arst_data", blk_data, 512'(0));
    @(posedge clk); #2 rst = 1'b0;
    model_clear();
    stall_mode = 1'b0;
    repeat (2) @(posedge clk);
    run_abc_and_check("abc_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
